llc_miss_handler: RTL and testbench

Line-fill and victim-writeback engine sitting directly downstream of the LLC. It accepts one miss at a time from the cache. When the victim is dirty, it first writes the victim line back byte-serially over the memory bus. It then reads the missing line byte-serially and returns the assembled line to the cache as a single-cycle fill.

---
 rtl/llc_miss_handler.sv | 185 ++++++++++++++++++
 tb/tb_llc_miss_handler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_miss_handler.sv
// llc_miss_handler: LLC line-fill and dirty-victim writeback engine.
// One miss at a time. A dirty victim is written back byte-serially, then the
// missing line is read byte-serially and returned to the cache as a one-cycle fill.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   miss_valid/miss_ready       miss handshake; miss_addr, miss_wb,
//                               victim_addr, victim_data are latched on accept
//   fill_valid/addr/data        one-cycle line return to the cache
//   crit_valid/crit_data        early requested byte (LLC_MISS_CRIT_FIRST_EN only)
//   mem_req/we/addr/wdata       byte beat request to memory
//   mem_ack/mem_rdata           beat completion and read byte
// Optional feature macro: LLC_MISS_CRIT_FIRST_EN (critical-byte-first reads).
module llc_miss_handler #(
  parameter int LINE_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_valid,
  output logic                   miss_ready,
  input  logic [31:0]            miss_addr,
  input  logic                   miss_wb,
  input  logic [31:0]            victim_addr,
  input  logic [8*LINE_SIZE-1:0] victim_data,
  output logic                   fill_valid,
  output logic [31:0]            fill_addr,
  output logic [8*LINE_SIZE-1:0] fill_data,
  output logic                   crit_valid,
  output logic [7:0]             crit_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_rdata
);

  localparam int OFF_W = $clog2(LINE_SIZE);
  localparam int CW    = OFF_W + 1;
  localparam int LW    = 8 * LINE_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    RD,
    FILL
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [31-OFF_W:0] mbase;
  logic [31-OFF_W:0] vbase;
  logic [LW-1:0]     vline;
  logic [LW-1:0]     lbuf;
  logic [OFF_W-1:0]  start;
  logic [OFF_W-1:0]  acc_start;

  logic [CW-1:0]     cnt_inc;
  logic              last_beat;
  logic              beat_ack;
  logic [OFF_W-1:0]  nxt_off;
  logic [OFF_W-1:0]  rd_off;
  logic [LW-1:0]     lbuf_wr;
  logic              unused_bits;

  assign miss_ready = (state == IDLE) && !reset;
  assign beat_ack   = mem_req && mem_ack;
  assign cnt_inc    = cnt + CW'(1);
  // Terminal count uses the extra counter bit so it never aliases 0.
  assign last_beat  = (cnt_inc == CW'(LINE_SIZE));
  assign nxt_off    = cnt[OFF_W-1:0] + OFF_W'(1);
  assign rd_off     = cnt[OFF_W-1:0] + start;

  assign unused_bits = ^{victim_addr[OFF_W-1:0],
                         miss_addr[OFF_W-1:0]};

  always_comb begin
    lbuf_wr = lbuf;
    lbuf_wr[{rd_off, 3'b000} +: 8] = mem_rdata;
  end

`ifdef LLC_MISS_CRIT_FIRST_EN
  assign acc_start = miss_addr[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      start      <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      if (state == IDLE && miss_valid)
        start <= acc_start;
      crit_valid <= (state == RD) && beat_ack && (cnt == '0);
      if ((state == RD) && beat_ack && (cnt == '0))
        crit_data <= mem_rdata;
    end
  end
`else
  assign acc_start  = '0;
  assign start      = '0;
  assign crit_valid = 1'b0;
  assign crit_data  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mbase      <= '0;
      vbase      <= '0;
      vline      <= '0;
      lbuf       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
    end else begin
      fill_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (miss_valid) begin
            mbase   <= miss_addr[31:OFF_W];
            vbase   <= victim_addr[31:OFF_W];
            vline   <= victim_data;
            cnt     <= '0;
            mem_req <= 1'b1;
            if (miss_wb) begin
              state     <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= {victim_addr[31:OFF_W],
                            {OFF_W{1'b0}}};
              mem_wdata <= victim_data[7:0];
            end else begin
              state     <= RD;
              mem_we    <= 1'b0;
              mem_addr  <= {miss_addr[31:OFF_W],
                            acc_start};
              mem_wdata <= '0;
            end
          end
        end
        WB: begin
          if (beat_ack) begin
            if (last_beat) begin
              state     <= RD;
              cnt       <= '0;
              mem_we    <= 1'b0;
              mem_addr  <= {mbase, start};
              mem_wdata <= '0;
            end else begin
              cnt       <= cnt_inc;
              mem_addr  <= {vbase, nxt_off};
              mem_wdata <= vline[{nxt_off, 3'b000} +: 8];
            end
          end
        end
        RD: begin
          if (beat_ack) begin
            lbuf <= lbuf_wr;
            if (last_beat) begin
              state      <= FILL;
              cnt        <= '0;
              mem_req    <= 1'b0;
              fill_valid <= 1'b1;
              fill_addr  <= {mbase, {OFF_W{1'b0}}};
              fill_data  <= lbuf_wr;
            end else begin
              cnt      <= cnt_inc;
              mem_addr <= {mbase, nxt_off + start};
            end
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_miss_handler.sv
// tb_llc_miss_handler: random and directed bench for llc_miss_handler.
// A beat-list/line model derived from the miss rules is checked every cycle.
module tb_llc_miss_handler;

  localparam int L  = 64;
  localparam int OW = $clog2(L);
  localparam int LW = 8 * L;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          miss_valid;
  logic          miss_ready;
  logic [31:0]   miss_addr;
  logic          miss_wb;
  logic [31:0]   victim_addr;
  logic [LW-1:0] victim_data;
  logic          fill_valid;
  logic [31:0]   fill_addr;
  logic [LW-1:0] fill_data;
  logic          crit_valid;
  logic [7:0]    crit_data;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  llc_miss_handler #(.LINE_SIZE(L)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_addr(miss_addr), .miss_wb(miss_wb),
    .victim_addr(victim_addr), .victim_data(victim_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  logic [7:0] salt = 8'h00;
  logic [7:0] mix = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory content is a pure function of address.
  assign mem_rdata = mem_addr[7:0] ^ salt ^ (mem_addr[15:8] & mix);

  function automatic logic [7:0] mem_at(input logic [31:0] a);
    return a[7:0] ^ salt ^ (a[15:8] & mix);
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] got,
                     input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        first;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0]   addr;
    logic [LW-1:0] data;
    logic [7:0]    crit;
    int            acc;
    int            lat;
  } fill_t;

  beat_t bq[$];
  fill_t fq[$];

  int acc_cnt = 0;
  int fill_cnt = 0;
  int rd_acks = 0;
  int crit_cnt = 0;
  int last_lat = 0;
  int last_fill_cyc = 0;
  int last_acc_cyc = 0;
  logic [31:0]   fw_addr, fr_addr, lr_addr, last_fill_addr;
  logic [7:0]    fw_data, crit_seen, crit_val;
  logic [LW-1:0] last_fill;
  logic          crit_due = 1'b0;

  beat_t cb;
  fill_t cf;
  bit    er, eq, ef;

  always @(negedge clk) begin
    if (reset) begin
      chk("ready_in_reset", LW'(miss_ready), LW'(0));
      bq.delete();
      fq.delete();
      crit_due = 1'b0;
    end else begin
      er = (bq.size() == 0) && (fq.size() == 0);
      eq = (bq.size() != 0);
      ef = (bq.size() == 0) && (fq.size() != 0);
      chk("miss_ready", LW'(miss_ready), LW'(er));
      chk("mem_req", LW'(mem_req), LW'(eq));
      chk("fill_valid", LW'(fill_valid), LW'(ef));
      chk("crit_valid", LW'(crit_valid), LW'(crit_due));
      if (crit_due && crit_valid) begin
        chk("crit_data", LW'(crit_data), LW'(crit_val));
        crit_seen = crit_data;
        crit_cnt++;
      end
      crit_due = 1'b0;
      if (eq && mem_req) begin
        cb = bq[0];
        chk("mem_we", LW'(mem_we), LW'(cb.we));
        chk("mem_addr", LW'(mem_addr), LW'(cb.addr));
        if (cb.we)
          chk("mem_wdata", LW'(mem_wdata), LW'(cb.wd));
        if (mem_ack) begin
          if (cb.we && cb.first) begin
            fw_addr = mem_addr;
            fw_data = mem_wdata;
          end
          if (!cb.we) rd_acks++;
          if (!cb.we && cb.first) begin
            fr_addr = mem_addr;
`ifdef LLC_MISS_CRIT_FIRST_EN
            crit_due = 1'b1;
            crit_val = fq[0].crit;
`endif
          end
          if (!cb.we && cb.last) lr_addr = mem_addr;
          void'(bq.pop_front());
        end
      end
      if (ef && fill_valid) begin
        cf = fq.pop_front();
        chk("fill_addr", LW'(fill_addr), LW'(cf.addr));
        chk("fill_data", fill_data, cf.data);
        last_lat = cyc - cf.acc;
        if (cf.lat >= 0)
          chk("fill_latency", LW'(last_lat), LW'(cf.lat));
        last_fill = fill_data;
        last_fill_addr = fill_addr;
        last_fill_cyc = cyc;
        fill_cnt++;
      end
      if (er && miss_valid && miss_ready) begin
        logic [31:0] vb, mb;
        int st;
        vb = {victim_addr[31:OW], {OW{1'b0}}};
        mb = {miss_addr[31:OW], {OW{1'b0}}};
`ifdef LLC_MISS_CRIT_FIRST_EN
        st = int'(miss_addr[OW-1:0]);
`else
        st = 0;
`endif
        if (miss_wb) begin
          for (int i = 0; i < L; i++) begin
            cb.we = 1'b1;
            cb.addr = vb + 32'(i);
            cb.wd = victim_data[8*i +: 8];
            cb.first = (i == 0);
            cb.last = (i == L - 1);
            bq.push_back(cb);
          end
        end
        for (int i = 0; i < L; i++) begin
          cb.we = 1'b0;
          cb.addr = mb + 32'((st + i) % L);
          cb.wd = 8'h00;
          cb.first = (i == 0);
          cb.last = (i == L - 1);
          bq.push_back(cb);
        end
        cf.addr = mb;
        for (int i = 0; i < L; i++)
          cf.data[8*i +: 8] = mem_at(mb + 32'(i));
        cf.crit = mem_at(miss_addr);
        cf.acc = cyc;
        cf.lat = (mode != 0) ? -1 : (miss_wb ? 2 * L + 1 : L + 1);
        fq.push_back(cf);
        acc_cnt++;
        last_acc_cyc = cyc;
      end
    end
  end

  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: mem_ack = 1'b1;
        1: mem_ack = (cyc % 3 == 0);
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue(input logic [31:0] a, input logic wb,
                       input logic [31:0] va, input logic [LW-1:0] vd);
    int a0;
    int n;
    a0 = acc_cnt;
    n = 0;
    @(posedge clk);
    #1;
    miss_valid = 1'b1;
    miss_addr = a;
    miss_wb = wb;
    victim_addr = va;
    victim_data = vd;
    while (acc_cnt == a0 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (acc_cnt == a0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=%0d want=%0d", acc_cnt, a0 + 1);
    end
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((bq.size() != 0 || fq.size() != 0) && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bq.size() != 0 || fq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=%0d want=0", bq.size() + fq.size());
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=%0d want=finish", cyc);
    $fatal(1, "watchdog");
  end

  logic [LW-1:0] ramp, vd, fill_a;
  int f0, a0, c0, r0, n;

  initial begin
    miss_valid = 1'b0;
    miss_addr = '0;
    miss_wb = 1'b0;
    victim_addr = '0;
    victim_data = '0;
    for (int i = 0; i < L; i++) ramp[8*i +: 8] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mem_req", LW'(mem_req), LW'(0));
    chk("rst_mem_we", LW'(mem_we), LW'(0));
    chk("rst_mem_addr", LW'(mem_addr), LW'(0));
    chk("rst_mem_wdata", LW'(mem_wdata), LW'(0));
    chk("rst_fill_valid", LW'(fill_valid), LW'(0));
    chk("rst_fill_addr", LW'(fill_addr), LW'(0));
    chk("rst_fill_data", fill_data, LW'(0));
    chk("rst_crit", LW'({crit_valid, crit_data}), LW'(0));

    // Clean miss, ack always, identity memory.
    mode = 0;
    issue(32'h0000_1234, 1'b0, 32'h0, '0);
    wait_done();
    chk("clean_first_rd", LW'(fr_addr), LW'(32'h0000_1200));
    chk("clean_latency", LW'(last_lat), LW'(65));
    chk("clean_fill_addr", LW'(last_fill_addr), LW'(32'h0000_1200));
    chk("clean_fill_ramp", last_fill, ramp);
    fill_a = last_fill;

    // Dirty miss.
    for (int i = 0; i < L; i++) vd[8*i +: 8] = 8'hA0 ^ 8'(i);
    issue(32'h0000_4010, 1'b1, 32'h0000_8055, vd);
    wait_done();
    chk("dirty_first_wr", LW'(fw_addr), LW'(32'h0000_8040));
    chk("dirty_first_wd", LW'(fw_data), LW'(8'hA0));
    chk("dirty_latency", LW'(last_lat), LW'(129));

    // Ack every third cycle.
    mode = 1;
    issue(32'h0000_1234, 1'b0, 32'h0, '0);
    wait_done();
    chk("third_ack_fill", last_fill, fill_a);

    // Critical-byte-first ordering.
    mode = 0;
    c0 = crit_cnt;
    issue(32'h0000_203E, 1'b0, 32'h0, '0);
    wait_done();
`ifdef LLC_MISS_CRIT_FIRST_EN
    chk("crit_first_rd", LW'(fr_addr), LW'(32'h0000_203E));
    chk("crit_last_rd", LW'(lr_addr), LW'(32'h0000_203D));
    chk("crit_byte", LW'(crit_seen), LW'(8'h3E));
    chk("crit_pulses", LW'(crit_cnt - c0), LW'(1));
`else
    chk("crit_first_rd", LW'(fr_addr), LW'(32'h0000_2000));
    chk("crit_last_rd", LW'(lr_addr), LW'(32'h0000_203F));
    chk("crit_pulses", LW'(crit_cnt - c0), LW'(0));
`endif
    chk("crit_fill_ramp", last_fill, ramp);

    // Reset during RD.
    f0 = fill_cnt;
    r0 = rd_acks;
    issue(32'h0000_3000, 1'b0, 32'h0, '0);
    n = 0;
    while (rd_acks - r0 < 9 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_req", LW'(mem_req), LW'(0));
    chk("post_rst_ready", LW'(miss_ready), LW'(1));
    repeat (80) @(posedge clk);
    #1;
    chk("post_rst_no_fill", LW'(fill_cnt - f0), LW'(0));
    issue(32'h0000_3456, 1'b0, 32'h0, '0);
    wait_done();
    chk("post_rst_refill", LW'(fill_cnt - f0), LW'(1));

    // miss_valid held through a dirty miss.
    a0 = acc_cnt;
    @(posedge clk);
    #1;
    miss_valid = 1'b1;
    miss_addr = 32'h0000_5000;
    miss_wb = 1'b1;
    victim_addr = 32'h0000_9000;
    victim_data = vd;
    n = 0;
    while (acc_cnt - a0 < 2 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    chk("btb_gap", LW'(last_acc_cyc - last_fill_cyc), LW'(1));
    wait_done();
    chk("btb_accepts", LW'(acc_cnt - a0), LW'(2));

    // Randomized misses.
    for (int t = 0; t < 40; t++) begin
      logic [LW-1:0] rv;
      mode = $urandom_range(0, 2);
      salt = 8'($urandom);
      mix = 8'($urandom);
      for (int w = 0; w < LW / 32; w++) rv[32*w +: 32] = $urandom;
      issue($urandom, 1'($urandom_range(0, 1)), $urandom, rv);
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
